// File: rtl/calc_pkg.sv
// Shared calculator datapath types and constants.
package calc_pkg;

  localparam int BCD_DIGITS = 5;
  localparam int BIN_W      = 16;

  typedef logic [19:0] bcd_word_t;
  typedef logic [15:0] calc_word_t;

  typedef enum logic {IDLE, CONV} bcd2bin_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD nibble correction step for reverse double-dabble: subtract 3 when the nibble is 8 or more.
module bcd_digit_adjust (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd8) ? (d - 4'd3) : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, start/done handshake).
// Optional macro BCD_TO_BIN_SATURATE_EN: saturate result to all ones on overflow instead of wrapping.
module bcd_to_bin_seq
  import calc_pkg::*;
#(
  parameter int BCD_DIGITS = calc_pkg::BCD_DIGITS,
  parameter int BIN_W      = calc_pkg::BIN_W,
  parameter int ITER       = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*BCD_DIGITS-1:0] bcd_in,
  output logic                    busy,
  output logic                    done,
  output logic [BIN_W-1:0]        result,
  output logic                    overflow,
  output logic                    err_digit
);

  localparam int SW = 4*BCD_DIGITS + ITER;
  localparam int CW = $clog2(ITER+1);

  bcd2bin_state_t   state;
  logic [SW-1:0]    sreg;
  logic [SW-1:0]    shifted;
  logic [SW-1:0]    sreg_nxt;
  logic [CW-1:0]    cnt;
  logic             err_digit_n;
  logic             bad_digit;
  logic [ITER-1:0]  bin_nxt;
  logic             ovf_nxt;
  logic [BIN_W-1:0] res_nxt;

  assign shifted = sreg >> 1;
  assign sreg_nxt[ITER-1:0] = shifted[ITER-1:0];

  // Only the BCD field is corrected; the binary field just collects shifted-out bits.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (shifted[ITER+4*g +: 4]),
      .q (sreg_nxt[ITER+4*g +: 4])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  assign bin_nxt = sreg_nxt[ITER-1:0];
  assign ovf_nxt = |(bin_nxt >> BIN_W);

`ifdef BCD_TO_BIN_SATURATE_EN
  assign res_nxt = ovf_nxt ? {BIN_W{1'b1}} : bin_nxt[BIN_W-1:0];
`else
  assign res_nxt = bin_nxt[BIN_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      err_digit_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      err_digit   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg        <= {bcd_in, {ITER{1'b0}}};
            cnt         <= '0;
            err_digit_n <= bad_digit;
            busy        <= 1'b1;
            state       <= CONV;
          end
        end
        CONV: begin
          sreg <= sreg_nxt;
          cnt  <= cnt + 1'b1;
          // The final iteration's shifted value is used directly for the outputs.
          if (cnt == CW'(ITER-1)) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
            err_digit <= err_digit_n;
            if (err_digit_n) begin
              result   <= '0;
              overflow <= 1'b0;
            end else begin
              result   <= res_nxt;
              overflow <= ovf_nxt;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq (honours BCD_TO_BIN_SATURATE_EN for expected results).
module tb_bcd_to_bin_seq;
  import calc_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  bcd_word_t  bcd_in;
  logic       busy;
  logic       done;
  calc_word_t result;
  logic       overflow;
  logic       err_digit;

  int checks = 0;
  int errors = 0;

  bcd_to_bin_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .err_digit (err_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] bcd;
    logic [15:0] res;
    logic        ovf;
    logic        err;
  } vec_t;

  vec_t vecs [9];

`ifdef BCD_TO_BIN_SATURATE_EN
  localparam logic [15:0] R65536 = 16'hFFFF;
  localparam logic [15:0] R99999 = 16'hFFFF;
`else
  localparam logic [15:0] R65536 = 16'h0000;
  localparam logic [15:0] R99999 = 16'h869F;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start one conversion; lat = edges after the sampling edge until done, busy_cyc = cycles busy was seen high.
  task automatic do_conv(input logic [19:0] bcd, output int lat, output int busy_cyc);
    @(negedge clk);
    bcd_in = bcd;
    start  = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    bcd_in   = 20'hFFFFF;
    busy_cyc = busy ? 1 : 0;
    lat      = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cyc++;
    end
  endtask

  initial begin
    int lat, bc, ndone;

    vecs[0] = '{20'h00000, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{20'h12345, 16'h3039, 1'b0, 1'b0};
    vecs[2] = '{20'h65535, 16'hFFFF, 1'b0, 1'b0};
    vecs[3] = '{20'h65536, R65536,   1'b1, 1'b0};
    vecs[4] = '{20'h99999, R99999,   1'b1, 1'b0};
    vecs[5] = '{20'h1A234, 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{20'h00042, 16'h002A, 1'b0, 1'b0};
    vecs[7] = '{20'h54321, 16'hD431, 1'b0, 1'b0};
    vecs[8] = '{20'h00001, 16'h0001, 1'b0, 1'b0};

    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",     busy,      0);
    chk("reset_done",     done,      0);
    chk("reset_result",   result,    0);
    chk("reset_overflow", overflow,  0);
    chk("reset_err",      err_digit, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_conv(vecs[i].bcd, lat, bc);
      chk($sformatf("v%0d_latency", i),  lat,       17);
      chk($sformatf("v%0d_busy_cyc", i), bc,        17);
      chk($sformatf("v%0d_result", i),   result,    vecs[i].res);
      chk($sformatf("v%0d_overflow", i), overflow,  vecs[i].ovf);
      chk($sformatf("v%0d_err", i),      err_digit, vecs[i].err);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), done,   0);
      chk($sformatf("v%0d_hold", i),       result, vecs[i].res);
    end

    // Starts during conversion are ignored; a start in the done cycle is accepted.
    @(negedge clk);
    bcd_in = 20'h00100;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      start  = (lat + 1 == 3) || (lat + 1 == 10);
      bcd_in = 20'h00999;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("ignore_latency", lat,    17);
    chk("ignore_result",  result, 16'h0064);
    chk("ignore_busy_lo", busy,   0);
    bcd_in = 20'h00007;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    bcd_in = 20'h00999;
    chk("done_cycle_start_busy", busy, 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_cycle_latency", lat,    17);
    chk("done_cycle_result",  result, 16'h0007);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    bcd_in = 20'h54321;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy",     busy,      0);
    chk("midrst_done",     done,      0);
    chk("midrst_result",   result,    0);
    chk("midrst_overflow", overflow,  0);
    chk("midrst_err",      err_digit, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    do_conv(20'h54321, lat, bc);
    chk("after_rst_latency", lat,    17);
    chk("after_rst_result",  result, 16'hD431);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary expected finish");
    $fatal(1, "timeout");
  end

endmodule
